// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP MAC sequencer: FSM states, OPMODE
// words, operand tags and the stall limit used by the optional timeout.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_RESULT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'b00,
        TAG_FIRST = 2'b01,
        TAG_ACC   = 2'b10
    } tag_t;

    // Bit 0 selects X=M, bit 3 selects Z=P; upper nibble stays zero.
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

    localparam int              STALL_W   = 10;
    localparam logic [STALL_W-1:0] STALL_MAX = 10'd1023;

    function automatic logic [7:0] opm_of(input tag_t tag);
        logic [7:0] opm;
        case (tag)
            TAG_FIRST: opm = OPM_FIRST;
            TAG_ACC:   opm = OPM_ACC;
            default:   opm = OPM_HOLD;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Enable-gated tag shift register that delays each operand's tag so its
// OPMODE reaches the slice in step with the product; shifts only with CE.
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  tag_t din,
    output tag_t dout
);

    tag_t sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= TAG_NONE;
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a pipelined DSP slice (A1/B1, M, P, OPMODE regs) through N-term
// multiply-accumulate jobs. Define DSP_MAC_SEQ_TIMEOUT_EN for the stall abort.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    parameter int OPM_DLY  = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [17:0]      IN_A,
    input  logic [17:0]      IN_B,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    input  logic [47:0]      DSP_P,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [47:0]      RES_DATA,
    output logic             RES_ERR
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // IN_READY and RES_VALID depend only on state, never on the partner's signal.

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              first_q, first_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [47:0]       res_data_q, res_data_d;
    logic              ce;
    logic [17:0]       a_drv, b_drv;
    tag_t              tag_in, tag_out;

`ifdef DSP_MAC_SEQ_TIMEOUT_EN
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
    logic               res_err_q, res_err_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            drain_q     <= '0;
            res_data_q  <= '0;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
            stall_q     <= '0;
            abort_q     <= 1'b0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
            stall_q     <= stall_d;
            abort_q     <= abort_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        drain_d     = drain_q;
        res_data_d  = res_data_q;
        ce          = 1'b0;
        a_drv       = '0;
        b_drv       = '0;
        tag_in      = TAG_NONE;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
        stall_d     = stall_q;
        abort_d     = abort_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        state_d     = ST_ISSUE;
                        remaining_d = LEN;
                        first_d     = 1'b1;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
                        stall_d     = '0;
                        abort_d     = 1'b0;
`endif
                    end else begin
                        // Empty job: answer zero without clocking the slice.
                        state_d    = ST_RESULT;
                        res_data_d = '0;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
                        res_err_d  = 1'b0;
`endif
                    end
                end
            end
            ST_ISSUE: begin
                // A missing operand freezes the whole slice, keeping in-flight terms aligned.
                if (IN_VALID) begin
                    ce          = 1'b1;
                    a_drv       = IN_A;
                    b_drv       = IN_B;
                    tag_in      = first_q ? TAG_FIRST : TAG_ACC;
                    first_d     = 1'b0;
                    remaining_d = remaining_q - LEN_W'(1);
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
                    stall_d     = '0;
`endif
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
                else if (stall_q == STALL_MAX - 1'b1) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                    abort_d = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                ce = 1'b1;
                if (drain_q == DRN_LAST) begin
                    state_d    = ST_RESULT;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
                    res_data_d = abort_q ? 48'd0 : DSP_P;
                    res_err_d  = abort_q;
`else
                    res_data_d = DSP_P;
`endif
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_RESULT: begin
                if (RES_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dsp_tag_pipe #(
        .DEPTH (OPM_DLY)
    ) u_tag_pipe (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (ce),
        .din   (tag_in),
        .dout  (tag_out)
    );

    assign BUSY       = (state_q != ST_IDLE);
    assign IN_READY   = (state_q == ST_ISSUE);
    assign RES_VALID  = (state_q == ST_RESULT);
    assign RES_DATA   = res_data_q;
    assign DSP_A      = a_drv;
    assign DSP_B      = b_drv;
    assign DSP_CE     = ce;
    assign DSP_OPMODE = (state_q == ST_ISSUE || state_q == ST_DRAIN) ? opm_of(tag_out) : 8'h00;
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
    assign RES_ERR    = res_err_q;
`else
    assign RES_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP slice
// (A1/B1 -> M -> P with registered OPMODE, all on one clock enable).
module tb_dsp_mac_sequencer;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic [LEN_W-1:0]  LEN = '0;
    logic              BUSY;
    logic              IN_VALID = 1'b0;
    logic              IN_READY;
    logic [17:0]       IN_A = '0;
    logic [17:0]       IN_B = '0;
    logic [17:0]       DSP_A;
    logic [17:0]       DSP_B;
    logic [7:0]        DSP_OPMODE;
    logic              DSP_CE;
    logic [47:0]       DSP_P;
    logic              RES_VALID;
    logic              RES_READY = 1'b0;
    logic [47:0]       RES_DATA;
    logic              RES_ERR;

    dsp_mac_sequencer #(
        .LEN_W    (LEN_W),
        .PIPE_LAT (PIPE_LAT),
        .OPM_DLY  (1)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .LEN        (LEN),
        .BUSY       (BUSY),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_A       (IN_A),
        .IN_B       (IN_B),
        .DSP_A      (DSP_A),
        .DSP_B      (DSP_B),
        .DSP_OPMODE (DSP_OPMODE),
        .DSP_CE     (DSP_CE),
        .DSP_P      (DSP_P),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_DATA   (RES_DATA),
        .RES_ERR    (RES_ERR)
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural DSP slice ----------------
    logic signed [17:0] s_a1 = '0;
    logic signed [17:0] s_b1 = '0;
    logic signed [35:0] s_m  = '0;
    logic [7:0]         s_opm = '0;
    logic [47:0]        s_p  = '0;

    always @(posedge CLK) begin
        if (DSP_CE) begin
            s_a1  <= DSP_A;
            s_b1  <= DSP_B;
            s_m   <= 36'(s_a1) * 36'(s_b1);
            s_opm <= DSP_OPMODE;
            s_p   <= (s_opm[0] ? {{12{s_m[35]}}, s_m} : 48'd0) + (s_opm[3] ? s_p : 48'd0);
        end
    end
    assign DSP_P = s_p;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q[$];
    logic [17:0] ja[$];
    logic [17:0] jb[$];
    logic [7:0]  opm_log[$];
    logic [7:0]  opm_exp[6];

    logic        smp_ce, smp_hs, smp_ready, smp_res_valid, smp_busy, smp_res_err;
    logic [17:0] smp_a, smp_b;
    logic [7:0]  smp_opm;
    logic [47:0] smp_res_data;
    logic        prev_res_valid = 1'b0;
    int          ce_count = 0;
    int          last_hs_cyc = 0;
    int          rise_cyc = 0;
    int          wait_cycles = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set at the falling edge; tick samples 1 time unit later and
    // moves on to the next falling edge.
    task automatic tick();
        #1;
        smp_ce        = DSP_CE;
        smp_a         = DSP_A;
        smp_b         = DSP_B;
        smp_opm       = DSP_OPMODE;
        smp_ready     = IN_READY;
        smp_res_valid = RES_VALID;
        smp_res_data  = RES_DATA;
        smp_res_err   = RES_ERR;
        smp_busy      = BUSY;
        smp_hs        = IN_VALID && IN_READY;
        if (DSP_CE) begin
            ce_count++;
            opm_log.push_back(DSP_OPMODE);
        end
        if (smp_hs) last_hs_cyc = cyc;
        if (RES_VALID && !prev_res_valid) rise_cyc = cyc;
        prev_res_valid = RES_VALID;
        @(negedge CLK);
    endtask

    task automatic run_job(input int gap);
        int n;
        int waited;
        n = ja.size();
        START = 1'b1;
        LEN   = LEN_W'(n);
        tick();
        START = 1'b0;
        LEN   = '0;
        for (int i = 0; i < n; i++) begin
            IN_VALID = 1'b1;
            IN_A     = ja[i];
            IN_B     = jb[i];
            waited   = 0;
            do begin
                tick();
                waited++;
            end while (!smp_hs && waited < 20);
            check("issue_hs", {47'd0, smp_hs}, 48'd1);
            check("issue_ce", {47'd0, smp_ce}, 48'd1);
            check("dsp_a", {30'd0, smp_a}, {30'd0, ja[i]});
            check("dsp_b", {30'd0, smp_b}, {30'd0, jb[i]});
            IN_VALID = 1'b0;
            IN_A     = '0;
            IN_B     = '0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("bubble_ce", {47'd0, smp_ce}, 48'd0);
                end
            end
        end
    endtask

    task automatic wait_result(input int max_wait, input int hold, input logic exp_err);
        logic [47:0] exp_data;
        int waited;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!smp_res_valid && waited < max_wait);
        wait_cycles = waited;
        check("res_valid", {47'd0, smp_res_valid}, 48'd1);
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hDEAD_BEEF_0000;
        check("res_data", smp_res_data, exp_data);
        check("res_err", {47'd0, smp_res_err}, {47'd0, exp_err});
        check("busy_result", {47'd0, smp_busy}, 48'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_data", smp_res_data, exp_data);
            check("hold_busy", {47'd0, smp_busy}, 48'd1);
        end
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        tick();
        check("busy_after", {47'd0, smp_busy}, 48'd0);
        check("valid_after", {47'd0, smp_res_valid}, 48'd0);
    endtask

    task automatic check_opm_log(input string tag);
        check({tag, "_len"}, 48'(opm_log.size()), 48'd6);
        if (opm_log.size() == 6) begin
            for (int k = 0; k < 6; k++) check(tag, {40'd0, opm_log[k]}, {40'd0, opm_exp[k]});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ce_before;
        opm_exp = '{8'h08, 8'h01, 8'h09, 8'h09, 8'h08, 8'h08};
        @(negedge CLK);

        // Reset held with random inputs
        RST_N = 1'b0;
        for (int i = 0; i < 10; i++) begin
            START     = 1'($urandom_range(0, 1));
            LEN       = LEN_W'($urandom_range(0, 255));
            IN_VALID  = 1'($urandom_range(0, 1));
            IN_A      = 18'($urandom_range(0, 262143));
            IN_B      = 18'($urandom_range(0, 262143));
            RES_READY = 1'($urandom_range(0, 1));
            tick();
            check("rst_ce", {47'd0, smp_ce}, 48'd0);
        end
        check("rst_busy", {47'd0, smp_busy}, 48'd0);
        check("rst_in_ready", {47'd0, smp_ready}, 48'd0);
        check("rst_res_valid", {47'd0, smp_res_valid}, 48'd0);
        check("rst_res_data", smp_res_data, 48'd0);
        check("rst_res_err", {47'd0, smp_res_err}, 48'd0);
        check("rst_dsp_a", {30'd0, smp_a}, 48'd0);
        check("rst_dsp_b", {30'd0, smp_b}, 48'd0);
        check("rst_opmode", {40'd0, smp_opm}, 48'd0);
        START = 1'b0; LEN = '0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; RES_READY = 1'b0;
        RST_N = 1'b1;
        tick();
        check("idle_busy", {47'd0, smp_busy}, 48'd0);
        check("idle_ce", {47'd0, smp_ce}, 48'd0);

        // 2*3 + 4*5 + (-1)*7 = 19, back-to-back
        ja = '{18'd2, 18'd4, 18'h3FFFF};
        jb = '{18'd3, 18'd5, 18'd7};
        opm_log.delete();
        exp_q.push_back(48'd19);
        run_job(0);
        wait_result(20, 0, 1'b0);
        check("latency", 48'(rise_cyc - last_hs_cyc), 48'(PIPE_LAT + 1));
        check_opm_log("opm_seq");

        // Same job with two bubble cycles between pairs
        opm_log.delete();
        exp_q.push_back(48'd19);
        run_job(2);
        wait_result(20, 0, 1'b0);
        check("latency_bub", 48'(rise_cyc - last_hs_cyc), 48'(PIPE_LAT + 1));
        check_opm_log("opm_seq_bub");

        // Empty job: immediate zero result, slice untouched, back-pressured
        ce_before = ce_count;
        START = 1'b1;
        LEN   = '0;
        tick();
        START = 1'b0;
        exp_q.push_back(48'd0);
        wait_result(5, 5, 1'b0);
        check("len0_wait", 48'(wait_cycles), 48'd1);
        check("len0_ce", 48'(ce_count - ce_before), 48'd0);

        // Largest negative squared twice, then a FIRST-cleared follow-up
        ja = '{18'h20000, 18'h20000};
        jb = '{18'h20000, 18'h20000};
        exp_q.push_back(48'h8_0000_0000);
        run_job(0);
        wait_result(20, 0, 1'b0);
        ja = '{18'd1};
        jb = '{18'd1};
        exp_q.push_back(48'd1);
        run_job(0);
        wait_result(20, 0, 1'b0);

`ifdef DSP_MAC_SEQ_TIMEOUT_EN
        // Stall after one of two pairs: aborted job, then a clean job
        START = 1'b1;
        LEN   = LEN_W'(2);
        tick();
        START    = 1'b0;
        IN_VALID = 1'b1;
        IN_A     = 18'd5;
        IN_B     = 18'd5;
        tick();
        check("to_hs", {47'd0, smp_hs}, 48'd1);
        IN_VALID = 1'b0;
        exp_q.push_back(48'd0);
        wait_result(1100, 0, 1'b1);
        ja = '{18'd3};
        jb = '{18'd3};
        exp_q.push_back(48'd9);
        run_job(0);
        wait_result(20, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP slice (default pipeline: A1/B1, M, P and OPMODE registers enabled, no pre-adder) through N-term multiply-accumulate jobs.
- Accepts a job command and a valid/ready operand stream.
- Drives the slice's A, B, OPMODE and clock-enable pins so that P = Σ A_i·B_i.
- Holds the 48-bit result in a valid/ready output buffer until it is consumed.

Parameters:
- LEN_W, 8, width of the job length field (max N = 2^LEN_W − 1).
- PIPE_LAT, 3, cycles from operand issue to the term appearing on P.
- OPM_DLY, 1, cycles after operand issue at which that term's OPMODE is driven.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  job request; sampled only in IDLE.
- LEN  in  LEN_W  number of terms, captured with START.
- BUSY  out  1  high from job accept until the result is consumed.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  operand pair accepted when IN_VALID && IN_READY.
- IN_A  in  18  signed multiplicand.
- IN_B  in  18  signed multiplier.
- DSP_A  out  18  slice A input.
- DSP_B  out  18  slice B input.
- DSP_OPMODE  out  8  slice OPMODE.
- DSP_CE  out  1  common enable for CEA/CEB/CEM/CEP/CEOPMODE.
- DSP_P  in  48  slice P output.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed when RES_VALID && RES_READY.
- RES_DATA  out  48  accumulated result.
- RES_ERR  out  1  job aborted (timeout build only; otherwise tied 0).

Behaviour:
- Reset: all outputs 0; state IDLE; counters and tag shift register cleared. Reset mid-job abandons the job; no result is produced.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - START with LEN>0 → ISSUE. Capture LEN into the remaining counter. BUSY=1.
  - START with LEN=0 → RESULT with RES_DATA=0. The slice is not touched.
- ISSUE:
  - IN_READY=1.
  - On a handshake: DSP_A/DSP_B = IN_A/IN_B, DSP_CE=1, decrement remaining. Push a tag into an OPM_DLY-deep shift register: FIRST for term 0, ACC otherwise.
  - Last handshake (remaining=1) → DRAIN.
  - IN_VALID low: DSP_CE=0 and the tag shift register holds. The whole slice pipeline freezes, which keeps in-flight terms aligned (bubble-safe).
- OPMODE encoding, driven from the tag register output:
  - FIRST → 8'b0000_0001 (X=M, Z=0).
  - ACC → 8'b0000_1001 (X=M, Z=P).
  - NONE/drain → 8'b0000_1000 (X=0, Z=P, hold).
  - Bits 7:4 are always 0 (no pre-adder, no carry-in).
- DRAIN:
  - IN_READY=0, DSP_CE=1, DSP_A/DSP_B=0, NONE tags shifted in.
  - After PIPE_LAT cycles, capture DSP_P into RES_DATA → RESULT.
- RESULT:
  - RES_VALID=1; RES_DATA stable until the handshake.
  - Handshake → IDLE, BUSY=0.
  - START in RESULT/ISSUE/DRAIN is ignored (no queueing).
- Latency with no bubbles: RES_VALID rises PIPE_LAT+1 cycles after the last operand handshake.
- Arithmetic: 36-bit signed products, sign-extended, accumulated modulo 2^48. Overflow wraps and is not flagged.

Optional Feature:
- Macro: DSP_MAC_SEQ_TIMEOUT_EN.
- With the macro:
  - A 10-bit stall counter counts consecutive ISSUE cycles with IN_VALID=0.
  - At 1023: abandon the job, assert DSP_CE=1 for PIPE_LAT flush cycles with NONE tags, then RESULT with RES_ERR=1 and RES_DATA=0.
  - The counter clears on any handshake.
- Without the macro: RES_ERR is tied 0 and ISSUE waits indefinitely.

Decomposition:
- Shared package (dsp_pkg) holds:
  - state enum;
  - OPMODE constants OPM_FIRST, OPM_ACC, OPM_HOLD;
  - tag encoding (NONE/FIRST/ACC, 2 bits);
  - STALL_MAX constant.
- One natural sub-module: dsp_tag_pipe. It is the enable-gated OPM_DLY-deep tag shift register with async clear, reused for the flush path.

Test Plan:
- Reset → hold RST_N=0 for 10 cycles with random inputs → all outputs 0, DSP_CE=0. Release → IDLE, BUSY=0.
- START, LEN=3, pairs (2,3),(4,5),(−1,7) back-to-back against the real DSP slice model → RES_DATA=19, RES_VALID exactly PIPE_LAT+1 cycles after the third handshake. Check the OPMODE sequence 01,09,09,08…
- Same job with IN_VALID low 2 cycles between each pair → RES_DATA=19. DSP_CE=0 exactly in the bubble cycles.
- LEN=0 → RES_VALID next cycle, RES_DATA=0, DSP_CE never asserted. RES_READY held low 5 cycles → data stable, BUSY stays 1.
- Two jobs: (−131072,−131072)×2 then (1,1) → first result 2^35 (0x8_0000_0000), second result 1. Confirms the FIRST tag clears the accumulator.
- (TIMEOUT build) LEN=2, one pair then IN_VALID=0 → after 1023 stall cycles plus flush: RES_ERR=1, RES_DATA=0. A following LEN=1 (3,3) job gives 9, RES_ERR=0.
